// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter with per-message line locking, feeding a
// built-in 8N1 LSB-first UART serializer.
`timescale 1ns/1ps
module uart_tx_scheduler #(
    parameter int DELAY_FRAMES = 234,
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_tx,
    output logic                 busy,
    output logic                 locked,
    output logic [2:0]           grant_id,
    output logic                 timeout_err
);
    localparam int CW = $clog2(DELAY_FRAMES) + 1;
    localparam int SWL = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = (SWL > 16) ? SWL : 16;
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_FRAMES);
    localparam logic [SW-1:0] STALL_MAX = SW'(LOCK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic          tx_q, tx_d;
    logic          locked_q, locked_d;
    logic [2:0]    grant_q, grant_d;
    logic [2:0]    rr_q, rr_d;
    logic [SW-1:0] stall_q, stall_d;

    logic [7:0]    valid_pad;
    logic [7:0]    last_pad;
    logic [63:0]   data_pad;
    logic          cand_found;
    logic [2:0]    cand_idx;
    logic [2:0]    scan_idx;
    logic          accept;
    logic [2:0]    sel;
    logic          bit_done;

    assign valid_pad = 8'(req_valid);
    assign last_pad  = 8'(req_last);
    assign data_pad  = 64'(req_data);

    // first valid requester after the last one served, wrapping
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = rr_q;
        scan_idx   = rr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (scan_idx == 3'(NUM_REQ - 1)) ? 3'd0 : scan_idx + 3'd1;
            if (!cand_found && valid_pad[scan_idx]) begin
                cand_found = 1'b1;
                cand_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        locked_d    = locked_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        stall_d     = stall_q;
        accept      = 1'b0;
        timeout_err = 1'b0;
        req_ready   = '0;
        sel         = locked_q ? grant_q : cand_idx;
        bit_done    = (cnt_q + 1'b1) == CNT_LAST;

        unique case (state_q)
            IDLE: begin
                if (locked_q) begin
                    if (valid_pad[grant_q]) begin
                        accept = 1'b1;
                    end else if (stall_q == STALL_MAX) begin
                        locked_d    = 1'b0;
                        stall_d     = '0;
                        timeout_err = 1'b1;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end else begin
                    accept = cand_found;
                end
                if (accept) begin
                    state_d  = START;
                    cnt_d    = '0;
                    byte_d   = data_pad[{sel, 3'b000} +: 8];
                    grant_d  = sel;
                    rr_d     = sel;
                    locked_d = ~last_pad[sel];
                    stall_d  = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // strobe is masked while reset is held so nothing looks accepted
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && rst_n && (sel == 3'(i));
        end

        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = byte_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            byte_q   <= 8'd0;
            tx_q     <= 1'b1;
            locked_q <= 1'b0;
            grant_q  <= 3'd0;
            rr_q     <= 3'(NUM_REQ - 1);
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            tx_q     <= tx_d;
            locked_q <= locked_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            stall_q  <= stall_d;
        end
    end

    assign uart_tx  = tx_q;
    assign busy     = (state_q != IDLE);
    assign locked   = locked_q;
    assign grant_id = grant_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-position model of arbitration,
// locking and the serial line, plus literal per-scenario checks.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
    localparam int D  = 4;
    localparam int NR = 4;
    localparam int LT = 10;
    localparam int FR = 10 * D;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   req_ready;
    logic            uart_tx;
    logic            busy;
    logic            locked;
    logic [2:0]      grant_id;
    logic            timeout_err;

    uart_tx_scheduler #(
        .DELAY_FRAMES(D),
        .NUM_REQ(NR),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .uart_tx(uart_tx),
        .busy(busy),
        .locked(locked),
        .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] rq[NR][$];

    int         m_pos = -1;
    logic [7:0] m_byte = '0;
    logic       m_locked = 1'b0;
    int         m_owner = 0;
    int         m_rr = NR - 1;
    int         m_stall = 0;
    int         acc_total = 0;
    int         acc_cyc[NR];

    logic       line[$];
    int         ord[$];
    int         ord_cyc[$];
    int         busy_n = 0;
    int         lock_n = 0;
    int         tout_n = 0;
    int         tout_cyc = -1;
    int         rdy_cyc[NR];
    logic [7:0] dec[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [NR-1:0] e_rdy;
        logic          e_tx;
        logic          e_tout;
        int            a;
        int            bi;
        if (!rst_n) begin
            chk("rst_uart_tx", uart_tx, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_req_ready", req_ready, '0);
            chk("rst_locked", locked, 1'b0);
            chk("rst_grant_id", grant_id, 3'd0);
            chk("rst_timeout_err", timeout_err, 1'b0);
            m_pos = -1; m_locked = 1'b0; m_owner = 0;
            m_rr = NR - 1; m_stall = 0; acc_total = 0;
            line.delete(); ord.delete(); ord_cyc.delete();
            busy_n = 0; lock_n = 0; tout_n = 0; tout_cyc = -1;
            for (int i = 0; i < NR; i++) begin
                rdy_cyc[i] = -1;
                acc_cyc[i] = -1;
            end
        end else begin
            a = -1;
            e_tout = 1'b0;
            e_rdy = '0;
            if (m_pos < 0) begin
                if (m_locked) begin
                    if (req_valid[m_owner]) a = m_owner;
                    else if (m_stall == LT) e_tout = 1'b1;
                end else begin
                    for (int k = 1; k <= NR; k++)
                        if (a < 0 && req_valid[(m_rr + k) % NR]) a = (m_rr + k) % NR;
                end
            end
            if (a >= 0) e_rdy[a] = 1'b1;
            if (m_pos < 0) begin
                e_tx = 1'b1;
            end else begin
                bi = m_pos / D;
                e_tx = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : m_byte[bi-1];
            end
            chk("uart_tx", uart_tx, e_tx);
            chk("busy", busy, m_pos >= 0);
            chk("req_ready", req_ready, e_rdy);
            chk("locked", locked, m_locked);
            chk("grant_id", grant_id, m_owner);
            chk("timeout_err", timeout_err, e_tout);

            line.push_back(uart_tx);
            if (busy) busy_n++;
            if (locked) lock_n++;
            if (timeout_err) begin
                tout_n++;
                tout_cyc = cyc;
            end
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) begin
                    ord.push_back(i);
                    ord_cyc.push_back(cyc);
                    rdy_cyc[i] = cyc;
                end
            end

            if (a >= 0) begin
                m_byte = req_data[8*a +: 8];
                m_pos = 0;
                m_owner = a;
                m_rr = a;
                m_locked = !req_last[a];
                m_stall = 0;
                acc_cyc[a] = cyc;
                acc_total++;
                void'(rq[a].pop_front());
            end else if (m_pos >= 0) begin
                m_pos++;
                if (m_pos == FR) m_pos = -1;
            end else if (m_locked) begin
                if (m_stall == LT) begin
                    m_locked = 1'b0;
                    m_stall = 0;
                end else begin
                    m_stall++;
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_data[8*i +: 8] = rq[i][0][7:0];
                req_last[i] = rq[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) rq[i].delete();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive();
    endtask

    task automatic wait_acc(input int n, input int budget);
        int b = 0;
        while (acc_total < n && b < budget) begin
            tick();
            b++;
        end
        chk("accept_wait", acc_total >= n, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int b = 0;
        int pend;
        pend = 1;
        while (pend != 0 && b < budget) begin
            tick();
            b++;
            pend = (m_pos >= 0) ? 1 : 0;
            for (int i = 0; i < NR; i++) if (rq[i].size() > 0) pend = 1;
        end
        chk("idle_wait", pend, 0);
        repeat (3) tick();
    endtask

    task automatic decode();
        int i;
        logic [7:0] b;
        dec.delete();
        i = 0;
        while (i + FR <= line.size()) begin
            if (line[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = line[i + D*(k+1) + D/2];
                dec.push_back(b);
                i += FR;
            end else begin
                i++;
            end
        end
    endtask

    task automatic chk_line(input string nm, input string exp);
        decode();
        chk({nm, "_nbytes"}, dec.size(), exp.len());
        for (int k = 0; k < exp.len(); k++)
            if (k < dec.size()) chk({nm, "_byte"}, dec[k], exp[k]);
    endtask

    task automatic chk_ord(input string nm, input string exp);
        chk({nm, "_ngrants"}, ord.size(), exp.len());
        for (int k = 0; k < exp.len(); k++)
            if (k < ord.size()) chk({nm, "_grant"}, ord[k], int'(exp[k]) - 48);
    endtask

    initial begin
        int t;
        int st;
        int mis;
        logic [39:0] pat;
        drive();

        // 0x41 single byte: exact waveform
        do_reset();
        rq[0].push_back({1'b1, 8'h41});
        drive();
        wait_acc(1, 50);
        wait_idle(100);
        chk_line("t1", "A");
        pat = 40'h0F00000F0F;
        st = -1;
        for (int k = 0; k < line.size(); k++)
            if (st < 0 && line[k] == 1'b0) st = k;
        mis = 0;
        for (int k = 0; k < 40; k++)
            if (st < 0 || st + k >= line.size() || line[st+k] !== pat[39-k]) mis++;
        chk("t1_wave_mismatches", mis, 0);
        chk("t1_ready_pulses", ord.size(), 1);
        chk("t1_busy_clks", busy_n, 40);
        chk("t1_locked_clks", lock_n, 0);

        // all requesters valid: rr order, back-to-back
        do_reset();
        rq[0].push_back({1'b1, "A"});
        rq[1].push_back({1'b1, "B"});
        rq[2].push_back({1'b1, "C"});
        rq[3].push_back({1'b1, "D"});
        rq[0].push_back({1'b1, "E"});
        drive();
        wait_acc(5, 300);
        wait_idle(100);
        chk_ord("t2", "01230");
        for (int k = 1; k < ord_cyc.size(); k++)
            chk("t2_gap", ord_cyc[k] - ord_cyc[k-1], FR + 1);
        chk_line("t2", "ABCDE");

        // locked message vs competing requester
        do_reset();
        rq[1].push_back({1'b0, "H"});
        rq[1].push_back({1'b0, "i"});
        rq[1].push_back({1'b1, 8'h0A});
        rq[2].push_back({1'b1, "Z"});
        drive();
        wait_acc(4, 300);
        wait_idle(100);
        chk_ord("t3", "1112");
        chk_line("t3", "Hi\nZ");
        chk("t3_locked_clks", lock_n, 2 * (FR + 1));

        // lock timeout
        do_reset();
        rq[3].push_back({1'b0, "X"});
        drive();
        wait_acc(1, 50);
        rq[0].push_back({1'b1, "Q"});
        drive();
        wait_acc(2, 200);
        wait_idle(100);
        chk("t4_tout_pulses", tout_n, 1);
        chk("t4_tout_after_idle", tout_cyc - (rdy_cyc[3] + FR + 1), LT);
        chk("t4_grant_after_tout", rdy_cyc[0] - tout_cyc, 1);
        chk_ord("t4", "30");
        chk_line("t4", "XQ");

        // reset in DATA bit 3, then a clean frame
        do_reset();
        rq[0].push_back({1'b1, 8'hA5});
        drive();
        wait_acc(1, 50);
        t = acc_cyc[0];
        while (cyc < t + 18 && cyc < t + 100) tick();
        rq[0].push_back({1'b1, 8'h55});
        rst_n = 1'b0;
        drive();
        #1;
        chk("t5_tx_async", uart_tx, 1'b1);
        chk("t5_busy_async", busy, 1'b0);
        chk("t5_ready_async", req_ready, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive();
        wait_acc(1, 50);
        wait_idle(100);
        chk_line("t5", "U");
        chk_ord("t5", "0");

        // last byte arriving on the timeout cycle wins
        do_reset();
        rq[2].push_back({1'b0, "a"});
        drive();
        wait_acc(1, 50);
        t = acc_cyc[2] + FR + 1 + LT;
        while (cyc < t && cyc < t + 100) tick();
        rq[2].push_back({1'b1, "b"});
        drive();
        wait_acc(2, 100);
        wait_idle(100);
        chk("t6_tout_pulses", tout_n, 0);
        chk("t6_accept_cycle", rdy_cyc[2], t);
        chk_line("t6", "ab");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
